// File: rtl/sequence_generator_io_pkg.sv
// Shared types and default constants for the serial pattern generator and
// the matching sequence detector bench.
package seqgen_pkg;

  // Frame sequencing states: wait for a request, emit payload, emit idle gap.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  // Defaults shared with the detector side so both agree on the tracked pattern.
  localparam int         DEF_WIDTH   = 16;
  localparam int         DEF_PLEN    = 4;
  localparam logic [3:0] DEF_PATTERN = 4'b1101;
  localparam int         DEF_GAP     = 2;

endpackage

// File: rtl/sequence_generator_io_if.sv
// Request/stream bundle between a frame requester and the pattern generator.
// master: the side that requests frames and observes the serial stream.
// slave:  the generator itself.
interface sequence_generator_io_if
  import seqgen_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);

  localparam int HW = $clog2(WIDTH + 1);

  logic             start;
  logic [WIDTH-1:0] data;
  logic             ready;
  logic             o;
  logic             o_valid;
  logic             done;
  logic [HW-1:0]    hits;

  modport master (
    output start,
    output data,
    input  ready,
    input  o,
    input  o_valid,
    input  done,
    input  hits
  );

  modport slave (
    input  start,
    input  data,
    output ready,
    output o,
    output o_valid,
    output done,
    output hits
  );

endinterface

// File: rtl/sequence_generator_io_pattern_window.sv
// Sliding history of the last PLEN-1 emitted bits plus a compare of that
// history and the current bit against PATTERN (oldest bit is the MSB).
module pattern_window
  import seqgen_pkg::*;
#(
  parameter int              PLEN    = DEF_PLEN,
  parameter logic [PLEN-1:0] PATTERN = DEF_PATTERN
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic shift_en,
  input  logic bit_in,
  output logic match
);

  logic [PLEN-2:0] window_reg;
  logic [PLEN-2:0] window_next;

  // Shifted view of the history: new bit enters at bit 0, oldest drops off the top.
  generate
    for (genvar gi = 0; gi < PLEN - 1; gi++) begin : g_win
      if (gi == 0) begin : g_lsb
        assign window_next[gi] = bit_in;
      end else begin : g_upper
        assign window_next[gi] = window_reg[gi-1];
      end
    end
  endgenerate

  // History register; cleared at frame start so nothing leaks between frames.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      window_reg <= '0;
    end else if (clear) begin
      window_reg <= '0;
    end else if (shift_en) begin
      window_reg <= window_next;
    end
  end

  assign match = ({window_reg, bit_in} == PATTERN);

endmodule

// File: rtl/sequence_generator_io.sv
// Serial pattern transmitter: captures a WIDTH-bit word, shifts it out
// MSB-first, then forces GAP idle zeros. Counts PATTERN occurrences
// (overlapping) inside each frame and reports them with a done pulse.
module sequence_generator_io
  import seqgen_pkg::*;
#(
  parameter int              WIDTH   = DEF_WIDTH,
  parameter int              PLEN    = DEF_PLEN,
  parameter logic [PLEN-1:0] PATTERN = DEF_PATTERN,
  parameter int              GAP     = DEF_GAP
) (
  input logic                    clock,
  input logic                    reset,
  sequence_generator_io_if.slave bus
);

  localparam int HW = $clog2(WIDTH + 1);
  localparam int CW = $clog2(WIDTH + 1);
  localparam int GW = $clog2(GAP + 1);

  state_t           state_reg,   state_next;
  logic [WIDTH-1:0] shreg_reg,   shreg_next;
  logic [CW-1:0]    bit_cnt_reg, bit_cnt_next;
  logic [GW-1:0]    gap_cnt_reg, gap_cnt_next;
  logic [HW-1:0]    acc_reg,     acc_next;
  logic [HW-1:0]    hits_reg,    hits_next;
  logic             done_reg,    done_next;
  logic             o_valid_reg, o_valid_next;

  logic win_clear;
  logic win_shift;
  logic win_match;

  // The serial bit is always the shift register MSB; the register drains to
  // zero during SHIFT, so o is naturally 0 in GAP and IDLE.
  pattern_window #(
    .PLEN    (PLEN),
    .PATTERN (PATTERN)
  ) u_window (
    .clock    (clock),
    .reset    (reset),
    .clear    (win_clear),
    .shift_en (win_shift),
    .bit_in   (shreg_reg[WIDTH-1]),
    .match    (win_match)
  );

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Datapath registers; every output is taken straight from one of these.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      shreg_reg   <= '0;
      bit_cnt_reg <= '0;
      gap_cnt_reg <= '0;
      acc_reg     <= '0;
      hits_reg    <= '0;
      done_reg    <= 1'b0;
      o_valid_reg <= 1'b0;
    end else begin
      shreg_reg   <= shreg_next;
      bit_cnt_reg <= bit_cnt_next;
      gap_cnt_reg <= gap_cnt_next;
      acc_reg     <= acc_next;
      hits_reg    <= hits_next;
      done_reg    <= done_next;
      o_valid_reg <= o_valid_next;
    end
  end

  // Next-state and datapath update for the IDLE -> SHIFT -> GAP frame cycle.
  always_comb begin
    state_next   = state_reg;
    shreg_next   = shreg_reg;
    bit_cnt_next = bit_cnt_reg;
    gap_cnt_next = gap_cnt_reg;
    acc_next     = acc_reg;
    hits_next    = hits_reg;
    done_next    = 1'b0;
    o_valid_next = o_valid_reg;
    win_clear    = 1'b0;
    win_shift    = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (bus.start) begin
          shreg_next   = bus.data;
          bit_cnt_next = '0;
          acc_next     = '0;
          win_clear    = 1'b1;
          o_valid_next = 1'b1;
          state_next   = ST_SHIFT;
        end
      end

      ST_SHIFT: begin
        win_shift    = 1'b1;
        shreg_next   = {shreg_reg[WIDTH-2:0], 1'b0};
        bit_cnt_next = bit_cnt_reg + CW'(1);
        // Only count once a full pattern's worth of this frame has been sent.
        if (win_match && (bit_cnt_reg >= CW'(PLEN - 1))) begin
          acc_next = acc_reg + HW'(1);
        end
        if (bit_cnt_reg == CW'(WIDTH - 1)) begin
          gap_cnt_next = '0;
          o_valid_next = 1'b0;
          state_next   = ST_GAP;
        end
      end

      ST_GAP: begin
        gap_cnt_next = gap_cnt_reg + GW'(1);
        if (gap_cnt_reg == GW'(GAP - 1)) begin
          // Publish the count and pulse done in the first IDLE cycle.
          hits_next  = acc_reg;
          done_next  = 1'b1;
          state_next = ST_IDLE;
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  assign bus.ready   = (state_reg == ST_IDLE);
  assign bus.o       = shreg_reg[WIDTH-1];
  assign bus.o_valid = o_valid_reg;
  assign bus.done    = done_reg;
  assign bus.hits    = hits_reg;

endmodule

// File: doc/sequence_generator_io.md
# sequence_generator_io

Serial pattern transmitter and stimulus source for the `sequence_detector_io` family. It accepts a WIDTH-bit parallel word, shifts it out MSB-first on a single bit line, and then inserts a fixed zero gap. In parallel, it counts how many PATTERN occurrences it emitted in the frame, so a bench can check that count against a downstream detector's hit count. It sits upstream of the detector on the same one-bit `i` stream.

## Interface
- `WIDTH`, 16: bits per frame; must be at least PLEN.
- `PLEN`, 4: pattern length in bits.
- `PATTERN`, 4'b1101: pattern tracked by the hit counter; MSB is first in time.
- `GAP`, 2: number of forced-zero idle cycles after each frame; must be at least 2.
- `clock`  in  1: sole clock; all state updates on its rising edge.
- `reset`  in  1: asynchronous, active-low reset.
- `start`  in  1: frame request; only sampled while `ready` is high.
- `data`  in  WIDTH: frame payload, captured in the cycle `start` is accepted.
- `ready`  out  1: high in IDLE; reset value 1.
- `o`  out  1: serial bit; reset value 0.
- `o_valid`  out  1: high while a payload bit is on `o`; reset value 0.
- `done`  out  1: one-cycle pulse marking frame completion; reset value 0.
- `hits`  out  $clog2(WIDTH+1): PATTERN occurrences in the last completed frame, overlaps included; reset value 0.

## Operation
- FSM states: IDLE, SHIFT, GAP. The state register is cleared to IDLE by `reset`.
- IDLE:
  - `ready`=1, `o`=0, `o_valid`=0.
  - On `start`=1, the block latches `data` into the shift register.
  - It also clears the bit counter, the match window and the hit accumulator, then goes to SHIFT.
- SHIFT:
  - `o` = shreg[WIDTH-1] and `o_valid`=1.
  - The shift register shifts left by one and fills with 0.
  - After WIDTH bits have been emitted, the FSM goes to GAP.
- GAP:
  - `o`=0 and `o_valid`=0 for exactly GAP cycles, then the FSM returns to IDLE.
  - With GAP ≥ 2, a 1101 detector returns to S0 before the next frame, so the hit count is per-frame and unambiguous.
- Hit tracking:
  - Every bit emitted in SHIFT is shifted into a (PLEN-1)-bit window.
  - When {window, bit} == PATTERN and the in-frame bit count is at least PLEN, the accumulator increments.
  - The accumulator width is that of `hits`; it cannot overflow.
- Frame completion:
  - `hits` is loaded from the accumulator in the first IDLE cycle after GAP.
  - `done` pulses in that same cycle.
  - `hits` holds its value until the next frame completes or a reset occurs.
- `start` while not `ready`: ignored. The payload is not captured and no request is queued.
- Reset asserted at any point:
  - All outputs go to their reset values immediately.
  - The frame in progress is dropped.
  - `hits` returns to 0.

## Timing
- `start` accepted in cycle T (IDLE, `start`=1): `o` = data[WIDTH-1] with `o_valid`=1 in cycle T+1.
- Bit data[WIDTH-1-k] appears in cycle T+1+k, for k = 0..WIDTH-1.
- GAP occupies cycles T+WIDTH+1 .. T+WIDTH+GAP.
- Cycle T+WIDTH+GAP+1: `done`=1, `ready`=1, `hits` updated.
- Throughput: back-to-back frames are possible.
  - `start` held high is accepted in the `done` cycle.
  - Frame period is WIDTH+GAP+1 cycles.
- `o` and `o_valid` are registered outputs with no combinational path from `start` or `data`.

## Structure
- Package `seqgen_pkg` holds:
  - the state enum (IDLE, SHIFT, GAP);
  - the default PATTERN and PLEN constants, shared with the detector bench.
- One sub-module, `pattern_window`:
  - ports: clock, reset, clear, shift_en, bit_in, match;
  - contents: the (PLEN-1)-bit history register and the PATTERN compare.
- The top level holds the FSM, shift register, bit and gap counters, and the hit accumulator.

## Test plan
- Single pattern: `data`=16'hD000.
  - Required: `o` = 1,1,0,1 then twelve 0s, `o_valid` high for 16 cycles.
  - Required: `hits`=1 with `done` at T+19.
- Maximum overlap: `data`=16'hDB6D.
  - Required: `hits`=5.
  - Required: a 1101 detector driven by `o` reports 5 hits during the frame.
- All zeros and all ones: 16'h0000 and 16'hFFFF.
  - Required: `hits`=0 for both.
  - Required: `o_valid` high exactly 16 cycles for both.
- Busy rejection: pulse `start` with `data`=16'hFFFF in cycle T+5 of a 16'hD000 frame.
  - Required: the stream is unchanged and `hits`=1.
  - Required: no second frame follows.
- Back-to-back: hold `start`=1 with 16'hD000 then 16'h000D.
  - Required: the second frame's first bit appears in the cycle after `done`.
  - Required: both frames report `hits`=1, and the gap zeros produce no cross-frame match.
- Reset mid-frame: assert `reset`=0 during cycle T+8.
  - Required: `o`=0, `o_valid`=0, `ready`=1, `done`=0 and `hits`=0 asynchronously.
  - Required: after release, a new frame with 16'hD000 gives `hits`=1.
